// File: rtl/mpu_pkg.sv
// Shared definitions for the TX stream arbiter.
//   tx_arb_state_t : arbiter FSM state encoding
//   FRAME_CNT_W    : width of the per-source frame counters
//   cnt_w()        : counter width for a range of n values, never below 1 bit
package mpu_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPass,
    StDrop,
    StGap
  } tx_arb_state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_len_guard.sv
// Per-frame byte counter with maximum-length detection.
//   clk_i/rst_i  : clock, synchronous active-high reset
//   start_i      : grant pulse, zeroes the byte counter
//   beat_i       : output handshake while passing a frame
//   src_last_i   : last flag of the selected source on this beat
//   first_o      : counter is at the first byte of the frame
//   at_max_o     : counter is at the final permitted byte (MAX_LEN-1)
//   trunc_o      : this beat is the final permitted byte but not the source last
module frame_len_guard
  import mpu_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic beat_i,
  input  logic src_last_i,
  output logic first_o,
  output logic at_max_o,
  output logic trunc_o
);

  localparam int unsigned CntW = cnt_w(MAX_LEN);
  localparam logic [CntW-1:0] LastIdx = CntW'(MAX_LEN - 1);

  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (start_i) begin
      byte_cnt_d = '0;
    end else if (beat_i) begin
      byte_cnt_d = byte_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign first_o  = (byte_cnt_q == '0);
  assign at_max_o = (byte_cnt_q == LastIdx);
  assign trunc_o  = beat_i & at_max_o & ~src_last_i;

endmodule

// File: rtl/tx_stream_arbiter.sv
// Packet-granular arbiter sharing one TX byte stream between two AXI-stream sources.
// Source 0 has priority, source 1 is protected from starvation by a streak limit.
// The grant is held for a whole frame; frames are truncated at MAX_LEN and followed
// by GAP_CYCLES idle cycles.
//   clk_i/rst_i          : clock, synchronous active-high reset
//   enable_i             : permits new grants
//   s0_axis_* / s1_axis_*: byte sources (valid/ready/last/data)
//   m_axis_*             : output stream towards tx_chain, with start-of-packet flag
//   err_clr_i            : clears err_oversize_o
//   err_oversize_o       : sticky truncation flag
//   busy_o               : FSM not idle
//   frame_cnt0_o/1_o     : frames emitted per source, wrapping
module tx_stream_arbiter
  import mpu_pkg::*;
#(
  parameter int unsigned MAX_LEN       = 1024,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned MAX_HI_STREAK = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   s0_axis_valid_i,
  output logic                   s0_axis_ready_o,
  input  logic                   s0_axis_last_i,
  input  logic [7:0]             s0_axis_data_i,
  input  logic                   s1_axis_valid_i,
  output logic                   s1_axis_ready_o,
  input  logic                   s1_axis_last_i,
  input  logic [7:0]             s1_axis_data_i,
  output logic                   m_axis_valid_o,
  input  logic                   m_axis_ready_i,
  output logic [7:0]             m_axis_data_o,
  output logic                   m_axis_last_o,
  output logic                   m_axis_sop_o,
  input  logic                   err_clr_i,
  output logic                   err_oversize_o,
  output logic                   busy_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt0_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt1_o
);

  localparam int unsigned HsW  = cnt_w(MAX_HI_STREAK + 1);
  localparam int unsigned GapW = cnt_w(GAP_CYCLES);
  localparam logic [HsW-1:0]  HsMax   = HsW'(MAX_HI_STREAK);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam tx_arb_state_t   PostFrame = (GAP_CYCLES == 0) ? StIdle : StGap;

  tx_arb_state_t          state_q, state_d;
  logic                   sel_q, sel_d;
  logic [HsW-1:0]         hi_streak_q, hi_streak_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                   err_q, err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt0_q, frame_cnt0_d;
  logic [FRAME_CNT_W-1:0] frame_cnt1_q, frame_cnt1_d;

  logic       s_valid, s_last;
  logic [7:0] s_data;
  logic       grant, grant_s1;
  logic       first, at_max, trunc;
  logic       pass_hs, out_last_hs, drop_done, gap_done;

  // Selected-source view
  assign s_valid = sel_q ? s1_axis_valid_i : s0_axis_valid_i;
  assign s_last  = sel_q ? s1_axis_last_i  : s0_axis_last_i;
  assign s_data  = sel_q ? s1_axis_data_i  : s0_axis_data_i;

  // Source 1 wins when source 0 is absent or has used up its streak allowance
  assign grant_s1 = s1_axis_valid_i & ((hi_streak_q >= HsMax) | ~s0_axis_valid_i);
  assign grant    = (state_q == StIdle) & enable_i & (s0_axis_valid_i | s1_axis_valid_i);

  assign pass_hs     = (state_q == StPass) & s_valid & m_axis_ready_i;
  assign out_last_hs = pass_hs & (s_last | at_max);
  assign drop_done   = (state_q == StDrop) & s_valid & s_last;
  assign gap_done    = (state_q == StGap) & (gap_cnt_q == GapLast);

  frame_len_guard #(
    .MAX_LEN (MAX_LEN)
  ) u_len_guard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (grant),
    .beat_i     (pass_hs),
    .src_last_i (s_last),
    .first_o    (first),
    .at_max_o   (at_max),
    .trunc_o    (trunc)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant) state_d = StPass;
      StPass: begin
        if (trunc) begin
          state_d = StDrop;
        end else if (out_last_hs) begin
          state_d = PostFrame;
        end
      end
      StDrop: if (drop_done) state_d = PostFrame;
      StGap:  if (gap_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    s0_axis_ready_o = 1'b0;
    s1_axis_ready_o = 1'b0;
    m_axis_valid_o  = 1'b0;
    m_axis_data_o   = 8'h00;
    m_axis_last_o   = 1'b0;
    m_axis_sop_o    = 1'b0;
    unique case (state_q)
      StPass: begin
        m_axis_valid_o  = s_valid;
        m_axis_data_o   = s_data;
        m_axis_last_o   = s_last | at_max;
        m_axis_sop_o    = first;
        s0_axis_ready_o = ~sel_q & m_axis_ready_i;
        s1_axis_ready_o = sel_q & m_axis_ready_i;
      end
      StDrop: begin
        // Sink the remainder of an oversize frame without forwarding it
        s0_axis_ready_o = ~sel_q;
        s1_axis_ready_o = sel_q;
      end
      default: ;
    endcase
  end

  assign busy_o         = (state_q != StIdle);
  assign err_oversize_o = err_q;
  assign frame_cnt0_o   = frame_cnt0_q;
  assign frame_cnt1_o   = frame_cnt1_q;

  // Datapath bookkeeping
  always_comb begin
    sel_d        = grant ? grant_s1 : sel_q;
    hi_streak_d  = hi_streak_q;
    gap_cnt_d    = '0;
    err_d        = err_q;
    frame_cnt0_d = frame_cnt0_q;
    frame_cnt1_d = frame_cnt1_q;

    if (grant && grant_s1) begin
      hi_streak_d = '0;
    end else if (out_last_hs && !sel_q && (hi_streak_q != HsMax)) begin
      hi_streak_d = hi_streak_q + HsW'(1);
    end

    if (state_q == StGap) begin
      gap_cnt_d = gap_cnt_q + GapW'(1);
    end

    // A truncation in the same cycle as a clear leaves the flag set
    if (trunc) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end

    if (out_last_hs) begin
      if (sel_q) begin
        frame_cnt1_d = frame_cnt1_q + FRAME_CNT_W'(1);
      end else begin
        frame_cnt0_d = frame_cnt0_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q        <= 1'b0;
      hi_streak_q  <= '0;
      gap_cnt_q    <= '0;
      err_q        <= 1'b0;
      frame_cnt0_q <= '0;
      frame_cnt1_q <= '0;
    end else begin
      sel_q        <= sel_d;
      hi_streak_q  <= hi_streak_d;
      gap_cnt_q    <= gap_cnt_d;
      err_q        <= err_d;
      frame_cnt0_q <= frame_cnt0_d;
      frame_cnt1_q <= frame_cnt1_d;
    end
  end

endmodule
